hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, total EX-stage cycles of a multiply/divide (legal 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports IF_ID_RegRs, IF_ID_RegRt  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have port IF_ID_UsesRt  input  1  ID instruction reads Rt as a source.
REQ-006 SHALL have ports ID_EX_RegRt  input  5, and ID_EX_MemRead  input  1  load destination in EX.
REQ-007 SHALL have port ID_Branch_Taken  input  1  branch in ID resolved taken this cycle.
REQ-008 SHALL have port EX_MulDiv_Start  input  1  multiply/divide present in EX this cycle.
REQ-009 SHALL have outputs PC_Write, IF_ID_Write, ID_EX_Write  1 each  pipeline register enables (1 = advance).
REQ-010 SHALL have outputs ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush  1 each  insert a NOP into the named register.
REQ-011 SHALL have output Stall_Cycles  16  performance count of stalled cycles.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and MD_BUSY, plus a 4-bit down-counter md_cnt.
REQ-013 In IDLE with EX_MulDiv_Start=1, the FSM SHALL enter MD_BUSY at the next edge with md_cnt=MD_LATENCY-1.
REQ-014 In MD_BUSY, md_cnt SHALL decrement each edge, and the FSM SHALL return to IDLE at the edge where md_cnt=1, giving exactly MD_LATENCY-1 busy cycles.
REQ-015 In MD_BUSY, outputs SHALL be PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, ID_EX_Bubble=0, IF_ID_Flush=0.
REQ-016 EX_MulDiv_Start SHALL be ignored in MD_BUSY, because it is the held instruction.
REQ-017 A load-use hazard SHALL be: ID_EX_MemRead=1, ID_EX_RegRt!=0, and (ID_EX_RegRt==IF_ID_RegRs, or IF_ID_UsesRt=1 and ID_EX_RegRt==IF_ID_RegRt).
REQ-018 On a load-use hazard in IDLE, the same cycle SHALL give PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, ID_EX_Write=1; it is purely combinational, so the stall self-clears next cycle once the bubble removes MemRead.
REQ-019 Register 0 SHALL never cause a hazard.
REQ-020 ID_Branch_Taken SHALL assert IF_ID_Flush=1 for that cycle only when in IDLE with no load-use hazard.
REQ-021 When a stall is active, the branch SHALL be suppressed; it re-evaluates when ID advances.
REQ-022 Priority SHALL be MD_BUSY > load-use > branch flush.
REQ-023 With no condition active, outputs SHALL be PC_Write=IF_ID_Write=ID_EX_Write=1 and all bubbles/flush=0.
REQ-024 Outputs SHALL be combinational from registered state plus current inputs, with no latches; all state SHALL be updated only on clk rising edge or rst_n.
REQ-025 EX_MulDiv_Start and a load-use hazard in the same IDLE cycle SHALL apply the load-use outputs that cycle, with MD_BUSY still entered next edge.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE, md_cnt=0, Stall_Cycles=0, and outputs SHALL be PC_Write=IF_ID_Write=ID_EX_Write=1, bubbles/flush=0, regardless of other inputs.
REQ-027 rst_n asserted mid-MD_BUSY SHALL abort immediately to IDLE, with no residual stall after release.
REQ-028 The first edge after rst_n rises SHALL evaluate inputs normally.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN defined: Stall_Cycles SHALL increment by 1 on each edge where PC_Write=0, saturating at 16'hFFFF.
REQ-030 Macro HAZARD_PERF_CNT_EN undefined: the counter SHALL not be built, Stall_Cycles SHALL be constant 0, and the port SHALL remain present.

Verification
REQ-031 Load-use: ID_EX_MemRead=1, ID_EX_RegRt=5, IF_ID_RegRs=5 -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for exactly 1 cycle.
REQ-032 R0 and UsesRt: MemRead=1, ID_EX_RegRt=0=IF_ID_RegRs -> no stall; ID_EX_RegRt=7=IF_ID_RegRt with IF_ID_UsesRt=0 -> no stall.
REQ-033 MulDiv: MD_LATENCY=4, one-cycle EX_MulDiv_Start pulse -> MD_BUSY for 3 cycles with ID_EX_Write=0, EX_MEM_Bubble=1, then IDLE; Stall_Cycles=3 when the macro is defined, 0 otherwise.
REQ-034 Priority: ID_Branch_Taken=1 together with a load-use hazard -> IF_ID_Flush=0, stall asserted; next cycle (hazard gone), branch still taken -> IF_ID_Flush=1.
REQ-035 Reset mid-op: rst_n low on the 2nd MD_BUSY cycle -> all outputs idle values immediately; after release no stall until a new start.
REQ-036 Saturation: with the macro defined and Stall_Cycles forced near 16'hFFFF via a long stall sequence -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall unit bus: ID/EX hazard inputs and pipeline-control outputs.
// master = pipeline side driving hazard inputs, slave = the hazard unit.
interface hazard_stall_unit_if;
    logic [4:0]  IF_ID_RegRs;
    logic [4:0]  IF_ID_RegRt;
    logic        IF_ID_UsesRt;
    logic [4:0]  ID_EX_RegRt;
    logic        ID_EX_MemRead;
    logic        ID_Branch_Taken;
    logic        EX_MulDiv_Start;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        ID_EX_Bubble;
    logic        EX_MEM_Bubble;
    logic        IF_ID_Flush;
    logic [15:0] Stall_Cycles;

    modport master (
        output IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_RegRt,
               ID_EX_MemRead, ID_Branch_Taken, EX_MulDiv_Start,
        input  PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble,
               EX_MEM_Bubble, IF_ID_Flush, Stall_Cycles
    );

    modport slave (
        input  IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_RegRt,
               ID_EX_MemRead, ID_Branch_Taken, EX_MulDiv_Start,
        output PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble,
               EX_MEM_Bubble, IF_ID_Flush, Stall_Cycles
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall control: multi-cycle mul/div stall, load-use stall,
// taken-branch flush, with priority MD_BUSY > load-use > branch.
// Optional macro HAZARD_PERF_CNT_EN builds a saturating stalled-cycle counter;
// without it Stall_Cycles is tied to zero.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_stall_unit_if.slave    if_hz
);
    typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

    localparam logic [3:0] LP_MD_INIT = 4'(MD_LATENCY - 1);

    state_t     r_state;
    logic [3:0] r_md_cnt;
    logic       w_load_use;
    logic       w_pc_write;

    // Load-use: a load in EX writes a register the ID instruction reads; R0 never hazards.
    assign w_load_use = if_hz.ID_EX_MemRead && (if_hz.ID_EX_RegRt != 5'd0) &&
                        ((if_hz.ID_EX_RegRt == if_hz.IF_ID_RegRs) ||
                         (if_hz.IF_ID_UsesRt && (if_hz.ID_EX_RegRt == if_hz.IF_ID_RegRt)));

    // Mul/div FSM: busy for MD_LATENCY-1 cycles after a start seen in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_md_cnt <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (if_hz.EX_MulDiv_Start) begin
                        r_state  <= MD_BUSY;
                        r_md_cnt <= LP_MD_INIT;
                    end
                end
                MD_BUSY: begin
                    // Start is the held instruction here, so it is ignored.
                    if (r_md_cnt == 4'd1) begin
                        r_state  <= IDLE;
                        r_md_cnt <= 4'd0;
                    end else begin
                        r_md_cnt <= r_md_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_md_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Output decode by priority; reset forces the free-running values.
    always_comb begin
        w_pc_write            = 1'b1;
        if_hz.IF_ID_Write     = 1'b1;
        if_hz.ID_EX_Write     = 1'b1;
        if_hz.ID_EX_Bubble    = 1'b0;
        if_hz.EX_MEM_Bubble   = 1'b0;
        if_hz.IF_ID_Flush     = 1'b0;
        if (rst_n) begin
            if (r_state == MD_BUSY) begin
                w_pc_write          = 1'b0;
                if_hz.IF_ID_Write   = 1'b0;
                if_hz.ID_EX_Write   = 1'b0;
                if_hz.EX_MEM_Bubble = 1'b1;
            end else if (w_load_use) begin
                // EX still advances so the bubble clears MemRead next cycle.
                w_pc_write          = 1'b0;
                if_hz.IF_ID_Write   = 1'b0;
                if_hz.ID_EX_Bubble  = 1'b1;
            end else if (if_hz.ID_Branch_Taken) begin
                if_hz.IF_ID_Flush   = 1'b1;
            end
        end
    end

    assign if_hz.PC_Write = w_pc_write;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    // Count every edge at which the PC is held, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign if_hz.Stall_Cycles = r_stall_cycles;
`else
    assign if_hz.Stall_Cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit against a rule-level model.
module tb_hazard_stall_unit;
    localparam int MD_LAT = 4;

    logic clk;
    logic rst_n;
    hazard_stall_unit_if u_if ();

    hazard_stall_unit #(.MD_LATENCY(MD_LAT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .if_hz (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: remaining busy cycles and stalled-cycle count.
    int m_busy  = 0;
    int m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive, check mid-cycle, advance model at the edge.
    task automatic cyc(input string tag, input logic rn, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] ert,
                       input logic mr, input logic br, input logic st);
        logic       lu;
        logic [5:0] exp_o;
        logic [5:0] got_o;
        rst_n                = rn;
        u_if.IF_ID_RegRs     = rs;
        u_if.IF_ID_RegRt     = rt;
        u_if.IF_ID_UsesRt    = urt;
        u_if.ID_EX_RegRt     = ert;
        u_if.ID_EX_MemRead   = mr;
        u_if.ID_Branch_Taken = br;
        u_if.EX_MulDiv_Start = st;
        if (!rn) begin
            m_busy  = 0;
            m_stall = 0;
        end
        lu = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
        // {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush}
        if (!rn)             exp_o = 6'b111000;
        else if (m_busy > 0) exp_o = 6'b000010;
        else if (lu)         exp_o = 6'b001100;
        else if (br)         exp_o = 6'b111001;
        else                 exp_o = 6'b111000;
        @(negedge clk);
        got_o = {u_if.PC_Write, u_if.IF_ID_Write, u_if.ID_EX_Write,
                 u_if.ID_EX_Bubble, u_if.EX_MEM_Bubble, u_if.IF_ID_Flush};
        chk(tag, 32'(got_o), 32'(exp_o));
        chk({tag, "_cnt"}, 32'(u_if.Stall_Cycles), 32'(m_stall));
        @(posedge clk);
        if (rn) begin
`ifdef HAZARD_PERF_CNT_EN
            if (!exp_o[5] && m_stall < 65535) m_stall++;
`endif
            if (m_busy > 0) m_busy--;
            else if (st)    m_busy = MD_LAT - 1;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        // Reset with hostile inputs still yields idle outputs.
        cyc("rst",      0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 1);
        cyc("rst2",     0, 5'd5, 5'd0, 0, 5'd5, 1, 1, 1);
        cyc("idle",     1, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0);
        // Load-use on Rs: one stall cycle, then bubble removes MemRead.
        cyc("lu_rs",    1, 5'd5, 5'd0, 0, 5'd5, 1, 0, 0);
        cyc("lu_clr",   1, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0);
        // R0 and UsesRt gating.
        cyc("r0",       1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
        cyc("rt_unused",1, 5'd1, 5'd7, 0, 5'd7, 1, 0, 0);
        cyc("rt_used",  1, 5'd1, 5'd7, 1, 5'd7, 1, 0, 0);
        // Branch vs load-use priority.
        cyc("br_lu",    1, 5'd9, 5'd0, 0, 5'd9, 1, 1, 0);
        cyc("br_go",    1, 5'd9, 5'd0, 0, 5'd0, 0, 1, 0);
        // Mul/div pulse: three busy cycles; start ignored while busy.
        cyc("md_start", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
        cyc("md_b1",    1, 5'd4, 5'd0, 0, 5'd4, 1, 1, 1);
        cyc("md_b2",    1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
        cyc("md_b3",    1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        cyc("md_done",  1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        // Start together with load-use: load-use now, busy next.
        cyc("md_lu",    1, 5'd6, 5'd0, 0, 5'd6, 1, 0, 1);
        cyc("md_lu_b1", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        // Reset on second busy cycle aborts with no residual stall.
        cyc("md_lu_b2r",0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        cyc("post_rst", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        cyc("post_rst2",1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        // Randomized traffic; small register range to make hazards common.
        for (int i = 0; i < 3000; i++) begin
            cyc("rnd", ($urandom_range(99) >= 3),
                5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom),
                5'($urandom_range(3)), 1'($urandom), 1'($urandom),
                ($urandom_range(9) == 0));
        end
`ifdef HAZARD_PERF_CNT_EN
        // Hold a load-use hazard long enough to hit saturation.
        for (int i = 0; i < 65600; i++)
            cyc("sat", 1, 5'd3, 5'd0, 0, 5'd3, 1, 0, 0);
        cyc("sat_hold", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
        cyc("sat_md",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
